return_stack: RTL and testbench

Hardware LIFO that holds return addresses for the 19-bit processor's call/ret flow. It sits beside the control unit: on a `call` the control unit pushes `pc + 1` here, and on a `ret` it takes `top_data` as `next_pc` and pops. It replaces any stack array held inside the control unit with a clocked, bounded store that reports overflow and underflow.

---
 rtl/return_stack.sv | 115 +++++++++++
 tb/tb_return_stack.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/return_stack.sv
// Bounded LIFO of return addresses for call/ret, with sticky overflow/underflow flags.
// Define RSTACK_CIRCULAR_EN to make a push while full overwrite the oldest entry instead of being dropped.
module return_stack #(
    parameter int DATA_W = 19,
    parameter int DEPTH  = 256,
    parameter int PTR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              err_clr,
    output logic [DATA_W-1:0] top_data,
    output logic              empty,
    output logic              full,
    output logic [PTR_W:0]    count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  top_ptr_q, top_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              mem_we;
    logic [PTR_W-1:0]  mem_waddr;
    logic [PTR_W-1:0]  top_m1;
    logic              ovf_set, unf_set;
    logic              is_empty, is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DEPTH_CNT);
    // Wraps modulo DEPTH because the pointer is exactly PTR_W bits wide.
    assign top_m1   = top_ptr_q - 1'b1;

    always_comb begin
        top_ptr_d = top_ptr_q;
        count_d   = count_q;
        mem_we    = 1'b0;
        mem_waddr = top_ptr_q;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;

        if (push && pop) begin
            if (!is_empty) begin
                // Pop-then-push collapses to replacing the top entry in place.
                mem_we    = 1'b1;
                mem_waddr = top_m1;
            end else begin
                mem_we    = 1'b1;
                top_ptr_d = top_ptr_q + 1'b1;
                count_d   = (PTR_W + 1)'(1);
                unf_set   = 1'b1;
            end
        end else if (push) begin
            if (!is_full) begin
                mem_we    = 1'b1;
                top_ptr_d = top_ptr_q + 1'b1;
                count_d   = count_q + 1'b1;
            end else begin
                ovf_set = 1'b1;
`ifdef RSTACK_CIRCULAR_EN
                // The next free slot aliases the oldest entry when full.
                mem_we    = 1'b1;
                top_ptr_d = top_ptr_q + 1'b1;
`endif
            end
        end else if (pop) begin
            if (!is_empty) begin
                top_ptr_d = top_m1;
                count_d   = count_q - 1'b1;
            end else begin
                unf_set = 1'b1;
            end
        end

        overflow_d  = (overflow_q  && !err_clr) || ovf_set;
        underflow_d = (underflow_q && !err_clr) || unf_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_ptr_q   <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            top_ptr_q   <= top_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage has no reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            mem[mem_waddr] <= push_data;
        end
    end

    assign top_data  = is_empty ? '0 : mem[top_m1];
    assign empty     = is_empty;
    assign full      = is_full;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_return_stack.sv
// Directed self-checking bench for return_stack, built with a 4-entry stack.
// Expected values follow the RSTACK_CIRCULAR_EN setting of the build.
module tb_return_stack;

    localparam int DATA_W = 19;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic              err_clr;
    logic [DATA_W-1:0] top_data;
    logic              empty;
    logic              full;
    logic [PTR_W:0]    count;
    logic              overflow;
    logic              underflow;

    int n_checks = 0;
    int n_fail   = 0;

    return_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .err_clr   (err_clr),
        .top_data  (top_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [DATA_W-1:0] d);
        push = 1'b1; push_data = d;
        tick();
        push = 1'b0;
    endtask

    task automatic do_pop;
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic do_both(input logic [DATA_W-1:0] d);
        push = 1'b1; pop = 1'b1; push_data = d;
        tick();
        push = 1'b0; pop = 1'b0;
    endtask

    task automatic do_clr;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; push_data = '0;
        #23;
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_unf", 32'(underflow), 32'd0);
        check_eq("rst_top", 32'(top_data), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic push/pop
        do_push(19'h00011); do_push(19'h00022); do_push(19'h00033);
        check_eq("p3_count", 32'(count), 32'd3);
        check_eq("p3_top", 32'(top_data), 32'h33);
        do_pop(); check_eq("pop1_top", 32'(top_data), 32'h22);
        do_pop(); check_eq("pop2_top", 32'(top_data), 32'h11);
        do_pop(); check_eq("pop3_top", 32'(top_data), 32'h0);
        check_eq("pop3_empty", 32'(empty), 32'd1);

        // Underflow and clear
        do_pop();
        check_eq("unf_set", 32'(underflow), 32'd1);
        check_eq("unf_count", 32'(count), 32'd0);
        do_clr();
        check_eq("unf_clr", 32'(underflow), 32'd0);
        err_clr = 1'b1; pop = 1'b1;
        tick();
        err_clr = 1'b0; pop = 1'b0;
        check_eq("unf_clr_wins", 32'(underflow), 32'd1);
        do_clr();

        // Fill to DEPTH and beyond
        do_push(19'd1); do_push(19'd2); do_push(19'd3); do_push(19'd4);
        check_eq("fill_full", 32'(full), 32'd1);
        check_eq("fill_ovf0", 32'(overflow), 32'd0);
        do_push(19'd5);
        check_eq("ovf_count", 32'(count), 32'd4);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
`ifdef RSTACK_CIRCULAR_EN
        check_eq("ovf_top", 32'(top_data), 32'd5);
        for (int i = 0; i < 4; i++) begin
            check_eq("ovf_popval", 32'(top_data), 32'(5 - i));
            do_pop();
        end
`else
        check_eq("ovf_top", 32'(top_data), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq("ovf_popval", 32'(top_data), 32'(4 - i));
            do_pop();
        end
`endif
        check_eq("ovf_empty", 32'(empty), 32'd1);
        do_clr();
        check_eq("ovf_clr", 32'(overflow), 32'd0);

        // Simultaneous push/pop on non-empty stack
        do_push(19'h00100); do_push(19'h00200);
        do_both(19'h7FFFF);
        check_eq("pp_count", 32'(count), 32'd2);
        check_eq("pp_top", 32'(top_data), 32'h7FFFF);
        check_eq("pp_unf", 32'(underflow), 32'd0);
        check_eq("pp_ovf", 32'(overflow), 32'd0);
        do_pop();
        check_eq("pp_pop_top", 32'(top_data), 32'h100);
        do_pop();
        check_eq("pp_empty", 32'(empty), 32'd1);

        // Simultaneous push/pop on empty stack
        do_both(19'h00ABC);
        check_eq("ppe_count", 32'(count), 32'd1);
        check_eq("ppe_top", 32'(top_data), 32'hABC);
        check_eq("ppe_unf", 32'(underflow), 32'd1);
        do_pop();
        do_clr();

        // Overflow raised in the same cycle as err_clr
        do_push(19'd7); do_push(19'd8); do_push(19'd9); do_push(19'd10);
        err_clr = 1'b1; push = 1'b1; push_data = 19'd11;
        tick();
        err_clr = 1'b0; push = 1'b0;
        check_eq("ovf_clr_wins", 32'(overflow), 32'd1);
        do_pop(); do_pop(); do_pop(); do_pop();
        check_eq("drain_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-sequence
        do_push(19'h00005); do_push(19'h00006);
        check_eq("pre_rst_count", 32'(count), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_count", 32'(count), 32'd0);
        check_eq("arst_top", 32'(top_data), 32'd0);
        check_eq("arst_ovf", 32'(overflow), 32'd0);
        check_eq("arst_unf", 32'(underflow), 32'd0);
        push = 1'b1; push_data = 19'h00077;
        tick();
        push = 1'b0;
        check_eq("rst_push_ignored", 32'(count), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        do_push(19'h00042);
        check_eq("post_rst_top", 32'(top_data), 32'h42);
        check_eq("post_rst_count", 32'(count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
